tc7_forward_converter: RTL and testbench
========================================

Name: tc7_forward_converter

Overview:
- Upstream stage of the mod-7 thermometer-code RNS datapath.
- Takes an unsigned binary operand and iteratively reduces it modulo 7, 3 bits per cycle; valid because 8 ≡ 1 (mod 7).
- Emits the residue as a 6-bit thermometer code, ready to drive an a/b operand of the mod-7 thermometer adder.
- Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
- DATA_W, 24, width of the binary operand. Must be a multiple of 3 and ≥ 3; elaboration error otherwise.
- NCH, DATA_W/3, derived; number of 3-bit chunks (number of ACCUM cycles).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  DATA_W  unsigned binary operand.
- out_valid  out  1  residue outputs are valid.
- out_ready  in  1  consumer accepts the residue.
- res_tc  out  6  residue, thermometer code: bit k (1..6) = 1 iff residue ≥ k.
- res_bin  out  3  residue in binary, 0..6; never 7.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; acc = 0; shift register = 0; chunk counter = 0.
  - out_valid = 0, res_tc = 000000, res_bin = 0, busy = 0.
  - in_ready = 1 while in reset and immediately after.
- State machine: IDLE → ACCUM → DONE → IDLE.
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: load shift register with in_data, acc = 0, cnt = 0, go to ACCUM.
  - ACCUM:
    - in_ready = 0.
    - Each cycle: acc ← mod7(acc + sreg[2:0]); sreg shifts right by 3; cnt increments.
    - When cnt == NCH-1, the final update happens and the next state is DONE.
  - DONE:
    - out_valid = 1.
    - res_bin = acc; res_tc = thermometer encoding of acc.
    - Outputs held stable until the cycle with out_ready = 1; on that edge go to IDLE with out_valid = 0.
- Latency: out_valid rises exactly NCH cycles after the accepting edge (8 cycles at default). The earliest next acceptance is the cycle after the out handshake.
- Throughput: one operand per NCH+2 cycles minimum; no overlap of input and output phases.
- mod7 arithmetic:
  - Sum range 0..13 (acc 0..6, chunk 0..7).
  - If sum ≥ 7, subtract 7; one conditional subtract is sufficient.
  - Chunk value 7 behaves as 0.
- Residue 0 encodes as res_tc = 000000. Residue 6 encodes as 111111.
- Boundary conditions:
  - in_valid held high during ACCUM/DONE: ignored, not consumed.
  - out_ready high before DONE: no effect.
  - out_ready held low in DONE: outputs and state frozen indefinitely.
  - in_data changes after acceptance: no effect on the result.
  - rst mid-ACCUM or mid-DONE: immediate return to reset values; the in-flight operand is discarded and no out_valid is produced.
  - Back-to-back operands: the second is accepted in the first IDLE cycle after the out handshake.

Decomposition:
- Shared package tc7_pkg:
  - constants RNS_M = 7 and TC_W = 6.
  - state enum {IDLE, ACCUM, DONE}.
  - function mod7_add3(acc[2:0], chunk[2:0]) → [2:0].
- Sub-module tc7_bin_to_therm: combinational 3-bit binary → 6-bit thermometer encoder. It is reused by later RNS blocks.

Test Plan:
- in_data = 100, out_ready = 1 → out_valid 8 cycles after acceptance, res_bin = 2, res_tc = 000011.
- in_data = 12345678 → res_bin = 2, res_tc = 000011. Then in_data = 6 → res_bin = 6, res_tc = 111111.
- Edge operands:
  - in_data = 0x000000 → res_bin = 0, res_tc = 000000.
  - in_data = 0xFFFFFF (2^24 − 1) → res_bin = 0, res_tc = 000000.
  - in_data = 7 → res_bin = 0, res_tc = 000000.
- Backpressure: in_data = 13, out_ready low for 5 cycles in DONE → out_valid, res_bin = 6 and res_tc = 111111 held constant. in_ready stays 0 until the cycle after out_ready = 1.
- Reset mid-operation: accept 100, assert rst on the 4th ACCUM cycle → all outputs return to reset values, in_ready = 1, no out_valid. Next operand 9 → res_bin = 2, res_tc = 000011.
- Exhaustive: random in_data, 1000 iterations, random in_valid/out_ready gaps → res_bin == in_data % 7, res_tc == thermometer(res_bin), no lost or duplicated results.

Source files
------------

// File: rtl/tc7_pkg.sv
// tc7_pkg: shared constants, FSM states and mod-7 helper for the thermometer-code RNS datapath
package tc7_pkg;
  localparam int RNS_M = 7;
  localparam int TC_W = 6;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [2:0] mod7_add3(input logic [2:0] acc, input logic [2:0] chunk);
    logic [3:0] s;
    s = {1'b0, acc} + {1'b0, chunk};
    return (s >= 4'(RNS_M)) ? 3'(s - 4'(RNS_M)) : s[2:0];
  endfunction
endpackage

// File: rtl/tc7_bin_to_therm.sv
// tc7_bin_to_therm: 3-bit binary residue to 6-bit thermometer code, bit k-1 set iff value >= k
module tc7_bin_to_therm
  import tc7_pkg::*;
(
  input  logic [2:0]      bin,
  output logic [TC_W-1:0] tc
);
  for (genvar k = 0; k < TC_W; k++) begin : g_tc
    assign tc[k] = bin >= 3'(k + 1);
  end
endmodule

// File: rtl/tc7_forward_converter.sv
// tc7_forward_converter: iterative binary-to-mod-7 reduction, 3 bits per cycle, thermometer-coded result
module tc7_forward_converter
  import tc7_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TC_W-1:0]   res_tc,
  output logic [2:0]        res_bin,
  output logic              busy
);
  localparam int NCH = DATA_W / 3;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  if (DATA_W % 3 != 0 || DATA_W < 3) begin : g_bad_width
    $error("DATA_W must be a multiple of 3 and at least 3");
  end
  state_t state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [2:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // state and datapath registers; reset discards any in-flight operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  // next state: load in IDLE, fold one chunk per ACCUM cycle (8 = 1 mod 7), hold in DONE until taken
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sreg_d = in_data;
        acc_d = '0;
        cnt_d = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d = mod7_add3(acc_q, sreg_q[2:0]);
        sreg_d = sreg_q >> 3;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(NCH - 1)) ? DONE : ACCUM;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign res_bin = out_valid ? acc_q : 3'd0;
  tc7_bin_to_therm u_therm (
    .bin(res_bin),
    .tc (res_tc)
  );
endmodule

// File: tb/tb_tc7_forward_converter.sv
// tb_tc7_forward_converter: vector table, corner sequences and randomized scoreboard for the mod-7 converter
module tb_tc7_forward_converter;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [23:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [5:0] res_tc;
  logic [2:0] res_bin;
  int checks = 0, failures = 0;
  typedef struct {
    logic [23:0] d;
    logic [2:0]  b;
    logic [5:0]  t;
  } vec_t;
  vec_t vecs[8];
  tc7_forward_converter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .res_tc(res_tc), .res_bin(res_bin), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", n, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int therm(input int r);
    return (1 << r) - 1;
  endfunction
  task automatic run_op(input logic [23:0] d, output logic [2:0] b, output logic [5:0] t, output int lat);
    chk("pre_in_ready", int'(in_ready), 1);
    in_valid = 1;
    in_data = d;
    out_ready = 1;
    step();
    in_valid = 0;
    in_data = 24'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    b = res_bin;
    t = res_tc;
    step();
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
  endtask
  initial begin
    logic [2:0] b;
    logic [5:0] t;
    int lat, seen, got, cyc;
    logic [23:0] q[$];
    vecs[0] = '{24'd100, 3'd2, 6'b000011};
    vecs[1] = '{24'd12345678, 3'd2, 6'b000011};
    vecs[2] = '{24'd6, 3'd6, 6'b111111};
    vecs[3] = '{24'h000000, 3'd0, 6'b000000};
    vecs[4] = '{24'hFFFFFF, 3'd0, 6'b000000};
    vecs[5] = '{24'd7, 3'd0, 6'b000000};
    vecs[6] = '{24'd13, 3'd6, 6'b111111};
    vecs[7] = '{24'd9, 3'd2, 6'b000011};
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_tc", int'(res_tc), 0);
    chk("rst_res_bin", int'(res_bin), 0);
    step();
    rst = 0;
    step();
    chk("idle_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].d, b, t, lat);
      chk($sformatf("vec%0d_bin", i), int'(b), int'(vecs[i].b));
      chk($sformatf("vec%0d_tc", i), int'(t), int'(vecs[i].t));
      chk($sformatf("vec%0d_lat", i), lat, 8);
    end
    in_valid = 1;
    in_data = 24'd13;
    out_ready = 0;
    step();
    in_data = 24'd5;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_res_bin", int'(res_bin), 6);
      chk("bp_res_tc", int'(res_tc), 6'b111111);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_busy", int'(busy), 1);
      step();
    end
    out_ready = 1;
    step();
    in_valid = 0;
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    in_valid = 1;
    in_data = 24'd100;
    step();
    in_valid = 0;
    repeat (3) step();
    chk("mid_busy", int'(busy), 1);
    rst = 1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_res_tc", int'(res_tc), 0);
    chk("midrst_res_bin", int'(res_bin), 0);
    step();
    rst = 0;
    seen = 0;
    repeat (12) begin
      step();
      seen += int'(out_valid);
    end
    chk("midrst_no_out", seen, 0);
    run_op(24'd9, b, t, lat);
    chk("after_rst_bin", int'(b), 2);
    chk("after_rst_tc", int'(t), 6'b000011);
    seen = 0;
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 60000) begin
      in_valid = (seen < 1000) && ($urandom_range(0, 2) != 0);
      in_data = 24'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      if (in_ready && out_valid) chk("rnd_overlap", 1, 0);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        seen++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          lat = int'(q.pop_front() % 24'd7);
          chk("rnd_bin", int'(res_bin), lat);
          chk("rnd_tc", int'(res_tc), therm(lat));
        end
        got++;
      end
      step();
      cyc++;
    end
    in_valid = 0;
    chk("rnd_results", got, 1000);
    chk("rnd_pending", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
